drtol2_snack_split: RTL and testbench
=====================================

// Module: drtol2_snack_split
// PURPOSE
//  Directory-side counterpart of the L2 arbiter. Takes the single drtol2 snack stream from the
//  directory and delivers each message to the L2 slices: one target slice for acks/fills, all
//  slices for snoops. Collects one snoop ack per slice for every broadcast and returns a single
//  merged l2todr snoop ack. All links use valid/retry: a beat transfers on valid && !retry.
// PARAMETERS
//  NSLICE   2   number of L2 slices (4 when SC_4PIPE is built)
//  SLICE_W  1   slice index width, $clog2(NSLICE)
//  SNACK_W  96  snack payload width
//  ACK_W    8   snoop ack payload width
// PORTS
//  clk                     in   1               clock
//  reset                   in   1               synchronous, active-high reset
//  drtol2_snack_valid      in   1               directory snack valid
//  drtol2_snack_retry      out  1               back-pressure to directory
//  drtol2_snack            in   SNACK_W         snack payload
//  drtol2_snack_bcast      in   1               1 = snoop, broadcast to all slices
//  drtol2_snack_slice      in   SLICE_W         target slice when bcast=0
//  drtol2d_snack_valid     out  NSLICE          per-slice valid
//  drtol2d_snack_retry     in   NSLICE          per-slice retry
//  drtol2d_snack           out  SNACK_W         payload, common to all slices
//  l2dtodr_snoop_ack_valid in   NSLICE          per-slice snoop ack valid
//  l2dtodr_snoop_ack_retry out  NSLICE          per-slice snoop ack retry
//  l2dtodr_snoop_ack       in   NSLICE*ACK_W    per-slice ack payload, slice i at [i*ACK_W+:ACK_W]
//  l2todr_snoop_ack_valid  out  1               merged ack valid
//  l2todr_snoop_ack_retry  in   1               directory retry
//  l2todr_snoop_ack        out  ACK_W           bitwise OR of all slice acks
// BEHAVIOUR
//  Reset: all valid outputs 0, both retry outputs 1, sent/got masks 0, FSM IDLE, buffer empty.
//  Input buffer: 1 entry. drtol2_snack_retry = buf_full && !buf_drain, so back-to-back flow needs
//   no bubble. A broadcast is also retried while FSM != IDLE. Latency: input accept -> slice
//   valid is 1 cycle.
//  Unicast: drtol2d_snack_valid[slice] = 1 only; buffer drains when that slice's retry = 0.
//   slice >= NSLICE: message is dropped at drain with no slice valid (directory bug, assert in sim).
//  Broadcast: valid[i] = buf_full & ~sent[i]; sent[i] sets on transfer to slice i. Buffer drains
//   the cycle the last unsent slice accepts. Each slice sees exactly one beat, and accepts may be
//   spread over any number of cycles.
//  FSM: IDLE -(broadcast enters buffer)-> BCAST -(sent all-ones & got all-ones)-> EMIT
//   -(merged ack taken, retry=0)-> IDLE; sent/got/ack accumulator clear on IDLE entry.
//  Ack collect: l2dtodr_snoop_ack_retry[i] = reset | (state!=BCAST) | got[i]. An accepted ack
//   sets got[i] and ORs its payload into the accumulator. An ack may arrive before every slice
//   has received the snoop. Simultaneous acks from several slices are all accepted in that cycle.
//  EMIT: l2todr_snoop_ack_valid = 1 and payload held stable until retry = 0.
//  Unicast traffic keeps flowing during BCAST/EMIT. Ordering is kept because the buffer is FIFO.
//  Reset mid-operation: in-flight snack and partial acks are discarded, with no output glitch
//   past the reset cycle.
// CONFIGURATION
//  DRSNACK_STATS_EN defined: adds out ports stat_ucast[15:0], stat_bcast[15:0], stat_stall[15:0],
//   saturating at 16'hFFFF and cleared by reset. They count unicast drains, broadcast completions
//   (EMIT taken) and cycles with drtol2_snack_valid && drtol2_snack_retry.
//  Not defined: those ports and counters are absent and all other behaviour is identical.
// TESTING
//  1 Unicast slice=1, payload 96'hA5, retries 0 -> valid[1]=1 at T+1, valid[0]=0, retry 0 throughout.
//  2 Unicast slice=0 with slice0 retry held 3 cycles -> valid[0] held 4 cycles with stable
//    payload, input retry=1 for a second message, zero lost beats.
//  3 Broadcast; slice0 accepts T+1, slice1 retries until T+4 -> slice0 gets exactly 1 beat,
//    slice1 gets 1 beat at T+4, buffer frees at T+4.
//  4 Broadcast, acks 8'h01 (slice1 first) then 8'h10 -> one merged ack 8'h11. A duplicate
//    slice1 ack is retried.
//  5 Broadcast then unicast back-to-back, merged-ack retry held 5 cycles -> unicast delivered
//    during EMIT, a second broadcast is retried until EMIT completes.
//  6 Reset asserted in BCAST with got=2'b01 -> next cycle all valids 0, FSM IDLE, a new
//    broadcast completes normally.

Source files
------------

// File: rtl/drtol2_snack_split.sv
`default_nettype none
// ============================================================================
// Module   : drtol2_snack_split
// Purpose  : Directory-side snack splitter. Buffers one directory snack and
//            delivers it to one L2 slice (ack/fill) or to every slice
//            (snoop). For each snoop broadcast it collects one ack per slice
//            and returns a single merged (bitwise OR) snoop ack.
//            All links use valid/retry: a beat moves on valid && !retry.
// Ports    : clk, reset (sync, active-high)
//            drtol2_snack_*      : directory -> splitter snack stream
//            drtol2d_snack_*     : splitter -> slices (payload shared)
//            l2dtodr_snoop_ack_* : slices -> splitter snoop acks
//            l2todr_snoop_ack_*  : merged snoop ack -> directory
// Config   : DRSNACK_STATS_EN adds stat_ucast/stat_bcast/stat_stall
//            saturating 16-bit event counters.
// Revision : 1.0 - initial release
// ============================================================================
module drtol2_snack_split #(
  parameter int NSLICE  = 2,
  parameter int SLICE_W = 1,
  parameter int SNACK_W = 96,
  parameter int ACK_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    drtol2_snack_valid,
  output logic                    drtol2_snack_retry,
  input  logic [SNACK_W-1:0]      drtol2_snack,
  input  logic                    drtol2_snack_bcast,
  input  logic [SLICE_W-1:0]      drtol2_snack_slice,
  output logic [NSLICE-1:0]       drtol2d_snack_valid,
  input  logic [NSLICE-1:0]       drtol2d_snack_retry,
  output logic [SNACK_W-1:0]      drtol2d_snack,
  input  logic [NSLICE-1:0]       l2dtodr_snoop_ack_valid,
  output logic [NSLICE-1:0]       l2dtodr_snoop_ack_retry,
  input  logic [NSLICE*ACK_W-1:0] l2dtodr_snoop_ack,
  output logic                    l2todr_snoop_ack_valid,
  input  logic                    l2todr_snoop_ack_retry,
  output logic [ACK_W-1:0]        l2todr_snoop_ack
`ifdef DRSNACK_STATS_EN
  ,
  output logic [15:0]             stat_ucast,
  output logic [15:0]             stat_bcast,
  output logic [15:0]             stat_stall
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BCAST = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                buf_full_q, buf_full_d;
  logic [SNACK_W-1:0]  buf_data_q;
  logic                buf_bcast_q;
  logic [SLICE_W-1:0]  buf_slice_q;
  logic [NSLICE-1:0]   sent_q, sent_d;
  logic [NSLICE-1:0]   got_q, got_d;
  logic [ACK_W-1:0]    acc_q, acc_d;

  logic                slice_ok;
  logic [NSLICE-1:0]   slice_xfer;
  logic                bcast_done;
  logic                buf_drain;
  logic                in_accept;
  logic [NSLICE-1:0]   ack_xfer;
  logic [ACK_W-1:0]    ack_or;
  logic                emit_taken;

  // A unicast index beyond the slice count is a directory bug; such a
  // message is drained without raising any slice valid.
  assign slice_ok = ({1'b0, buf_slice_q} < (SLICE_W+1)'(NSLICE));

  always_comb begin
    drtol2d_snack_valid = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (!reset && buf_full_q) begin
        if (buf_bcast_q)
          drtol2d_snack_valid[i] = ~sent_q[i];
        else
          drtol2d_snack_valid[i] = slice_ok && (buf_slice_q == SLICE_W'(i));
      end
    end
  end

  assign drtol2d_snack = buf_data_q;
  assign slice_xfer    = drtol2d_snack_valid & ~drtol2d_snack_retry;

  // Broadcast leaves the buffer in the cycle the last unsent slice accepts.
  assign bcast_done = &(sent_q | slice_xfer);
  assign buf_drain  = buf_full_q &
                      (buf_bcast_q ? bcast_done : (~slice_ok | (|slice_xfer)));

  // A second broadcast must wait until the previous merged ack is returned.
  assign drtol2_snack_retry = reset | (buf_full_q & ~buf_drain) |
                              (drtol2_snack_bcast & (state_q != ST_IDLE));
  assign in_accept = drtol2_snack_valid & ~drtol2_snack_retry;

  // Ack collection: each slice may ack once per broadcast, in any cycle of
  // BCAST, even before it has taken the snoop itself.
  assign l2dtodr_snoop_ack_retry = {NSLICE{reset | (state_q != ST_BCAST)}} | got_q;
  assign ack_xfer = l2dtodr_snoop_ack_valid & ~l2dtodr_snoop_ack_retry;

  always_comb begin
    ack_or = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (ack_xfer[i])
        ack_or = ack_or | l2dtodr_snoop_ack[i*ACK_W +: ACK_W];
    end
  end

  assign l2todr_snoop_ack_valid = ~reset & (state_q == ST_EMIT);
  assign l2todr_snoop_ack       = acc_q;
  assign emit_taken             = l2todr_snoop_ack_valid & ~l2todr_snoop_ack_retry;

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    buf_full_d = in_accept | (buf_full_q & ~buf_drain);
    sent_d     = sent_q;
    got_d      = got_q | ack_xfer;
    acc_d      = acc_q | ack_or;
    if (buf_full_q && buf_bcast_q)
      sent_d = sent_q | slice_xfer;
    case (state_q)
      ST_IDLE: begin
        if (in_accept && drtol2_snack_bcast)
          state_d = ST_BCAST;
      end
      ST_BCAST: begin
        if ((&sent_q) && (&got_q))
          state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (emit_taken) begin
          state_d = ST_IDLE;
          sent_d  = '0;
          got_d   = '0;
          acc_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      buf_full_q  <= 1'b0;
      buf_data_q  <= '0;
      buf_bcast_q <= 1'b0;
      buf_slice_q <= '0;
      sent_q      <= '0;
      got_q       <= '0;
      acc_q       <= '0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      sent_q     <= sent_d;
      got_q      <= got_d;
      acc_q      <= acc_d;
      if (in_accept) begin
        buf_data_q  <= drtol2_snack;
        buf_bcast_q <= drtol2_snack_bcast;
        buf_slice_q <= drtol2_snack_slice;
      end
    end
  end

  a_ucast_slice_range: assert property (
    @(posedge clk) disable iff (reset) (buf_full_q && !buf_bcast_q) |-> slice_ok);

`ifdef DRSNACK_STATS_EN
  logic [15:0] stat_ucast_q, stat_bcast_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ucast_q <= '0;
      stat_bcast_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (buf_drain && !buf_bcast_q && stat_ucast_q != 16'hFFFF)
        stat_ucast_q <= stat_ucast_q + 16'd1;
      if (emit_taken && stat_bcast_q != 16'hFFFF)
        stat_bcast_q <= stat_bcast_q + 16'd1;
      if (drtol2_snack_valid && drtol2_snack_retry && stat_stall_q != 16'hFFFF)
        stat_stall_q <= stat_stall_q + 16'd1;
    end
  end

  assign stat_ucast = stat_ucast_q;
  assign stat_bcast = stat_bcast_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_drtol2_snack_split.sv
`default_nettype none
// ============================================================================
// Module   : tb_drtol2_snack_split
// Purpose  : Directed self-checking bench for drtol2_snack_split
//            (NSLICE=2, SNACK_W=96, ACK_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_drtol2_snack_split;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_retry;
  logic [95:0] in_data;
  logic        in_bcast;
  logic [0:0]  in_slice;
  logic [1:0]  d_valid;
  logic [1:0]  d_retry;
  logic [95:0] d_data;
  logic [1:0]  ack_valid;
  logic [1:0]  ack_retry;
  logic [15:0] ack_data;
  logic        m_valid;
  logic        m_retry;
  logic [7:0]  m_data;
`ifdef DRSNACK_STATS_EN
  logic [15:0] stat_ucast, stat_bcast, stat_stall;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int beats0   = 0;
  int beats1   = 0;
  int n_macks  = 0;
  int b0, b1;

  drtol2_snack_split #(
    .NSLICE (2),
    .SLICE_W(1),
    .SNACK_W(96),
    .ACK_W  (8)
  ) u_dut (
    .clk                    (clk),
    .reset                  (reset),
    .drtol2_snack_valid     (in_valid),
    .drtol2_snack_retry     (in_retry),
    .drtol2_snack           (in_data),
    .drtol2_snack_bcast     (in_bcast),
    .drtol2_snack_slice     (in_slice),
    .drtol2d_snack_valid    (d_valid),
    .drtol2d_snack_retry    (d_retry),
    .drtol2d_snack          (d_data),
    .l2dtodr_snoop_ack_valid(ack_valid),
    .l2dtodr_snoop_ack_retry(ack_retry),
    .l2dtodr_snoop_ack      (ack_data),
    .l2todr_snoop_ack_valid (m_valid),
    .l2todr_snoop_ack_retry (m_retry),
    .l2todr_snoop_ack       (m_data)
`ifdef DRSNACK_STATS_EN
    ,
    .stat_ucast             (stat_ucast),
    .stat_bcast             (stat_bcast),
    .stat_stall             (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat and merged-ack counters, sampled at the active edge.
  always @(posedge clk) begin
    if (d_valid[0] && !d_retry[0]) beats0++;
    if (d_valid[1] && !d_retry[1]) beats1++;
    if (m_valid && !m_retry) n_macks++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_bcast = 1'b0; in_slice = '0;
    d_retry = 2'b00; ack_valid = 2'b00; ack_data = '0; m_retry = 1'b0;

    // Reset state
    smp();
    check("rst_in_retry", in_retry, 1);
    check("rst_d_valid", d_valid, 0);
    check("rst_ack_retry", ack_retry, 2'b11);
    check("rst_m_valid", m_valid, 0);
    cyc(); reset = 1'b0;
    smp();
    check("idle_in_retry", in_retry, 0);
    check("idle_ack_retry", ack_retry, 2'b11);

    // 1: unicast to slice 1
    cyc(); in_valid = 1; in_bcast = 0; in_slice = 1; in_data = 96'hA5;
    smp(); check("t1_in_retry", in_retry, 0);
    cyc(); in_valid = 0;
    smp();
    check("t1_d_valid", d_valid, 2'b10);
    check("t1_d_data", d_data, 96'hA5);
    check("t1_in_retry2", in_retry, 0);
    cyc(); smp(); check("t1_d_valid_off", d_valid, 2'b00);

    // 2: unicast to slice 0 with slice 0 retry held 3 cycles
    b0 = beats0; b1 = beats1;
    cyc(); d_retry = 2'b01; in_valid = 1; in_slice = 0; in_data = 96'h111;
    smp(); check("t2_in_retry", in_retry, 0);
    cyc(); in_slice = 1; in_data = 96'h222;
    smp();
    check("t2_d_valid", d_valid, 2'b01);
    check("t2_d_data", d_data, 96'h111);
    check("t2_in_retry_hold", in_retry, 1);
    for (int k = 0; k < 2; k++) begin
      cyc(); smp();
      check("t2_d_valid_hold", d_valid, 2'b01);
      check("t2_d_data_hold", d_data, 96'h111);
      check("t2_in_retry_hold", in_retry, 1);
    end
    cyc(); d_retry = 2'b00;
    smp();
    check("t2_d_valid_last", d_valid, 2'b01);
    check("t2_in_retry_free", in_retry, 0);
    cyc(); in_valid = 0;
    smp();
    check("t2_d_valid_2nd", d_valid, 2'b10);
    check("t2_d_data_2nd", d_data, 96'h222);
    cyc(); smp();
    check("t2_beats0", beats0 - b0, 1);
    check("t2_beats1", beats1 - b1, 1);

    // 3: broadcast, slice 1 retries until T+4
    cyc(); d_retry = 2'b10; in_valid = 1; in_bcast = 1; in_data = 96'hB0;
    b0 = beats0; b1 = beats1;
    smp(); check("t3_in_retry", in_retry, 0);
    cyc(); in_valid = 0; in_bcast = 0;
    smp();
    check("t3_d_valid_t1", d_valid, 2'b11);
    check("t3_d_data", d_data, 96'hB0);
    cyc(); smp(); check("t3_d_valid_t2", d_valid, 2'b10);
    cyc(); in_valid = 1; in_slice = 0; in_data = 96'hC3;
    smp();
    check("t3_d_valid_t3", d_valid, 2'b10);
    check("t3_in_retry_full", in_retry, 1);
    cyc(); d_retry = 2'b00;
    smp();
    check("t3_d_valid_t4", d_valid, 2'b10);
    check("t3_in_retry_t4", in_retry, 0);
    cyc(); in_valid = 0;
    smp();
    check("t3_ucast_valid", d_valid, 2'b01);
    check("t3_ucast_data", d_data, 96'hC3);
    cyc(); smp();
    check("t3_beats0", beats0 - b0, 2);
    check("t3_beats1", beats1 - b1, 1);

    // 4: acks for that broadcast, slice 1 first, duplicate retried
    cyc(); ack_valid = 2'b10; ack_data = {8'h01, 8'h00};
    smp();
    check("t4_ack_retry_a", ack_retry, 2'b00);
    check("t4_m_valid_early", m_valid, 0);
    cyc(); ack_data = {8'h80, 8'h00};
    smp(); check("t4_dup_retry", ack_retry, 2'b10);
    cyc(); ack_valid = 2'b11; ack_data = {8'h80, 8'h10};
    smp(); check("t4_ack_retry_b", ack_retry, 2'b10);
    cyc(); ack_valid = 2'b00;
    cyc(); smp();
    check("t4_m_valid", m_valid, 1);
    check("t4_m_data", m_data, 8'h11);
    cyc(); smp();
    check("t4_m_valid_off", m_valid, 0);
    check("t4_ack_retry_idle", ack_retry, 2'b11);
    check("t4_macks", n_macks, 1);

    // 5: broadcast + back-to-back unicast, merged ack retried 5 cycles
    cyc(); m_retry = 1; in_valid = 1; in_bcast = 1; in_data = 96'hB5;
    smp(); check("t5_in_retry", in_retry, 0);
    cyc(); in_bcast = 0; in_slice = 1; in_data = 96'h55;
    smp();
    check("t5_d_valid_b", d_valid, 2'b11);
    check("t5_in_retry_b2b", in_retry, 0);
    cyc(); in_valid = 0; ack_valid = 2'b11; ack_data = {8'h20, 8'h02};
    smp();
    check("t5_d_valid_u", d_valid, 2'b10);
    check("t5_d_data_u", d_data, 96'h55);
    check("t5_ack_retry", ack_retry, 2'b00);
    cyc(); ack_valid = 2'b00;
    cyc(); in_valid = 1; in_bcast = 0; in_slice = 0; in_data = 96'h66;
    smp();
    check("t5_m_valid", m_valid, 1);
    check("t5_m_data", m_data, 8'h22);
    check("t5_in_retry_emit_u", in_retry, 0);
    cyc(); in_bcast = 1; in_data = 96'hB6;
    smp();
    check("t5_emit_ucast", d_valid, 2'b01);
    check("t5_emit_ucast_data", d_data, 96'h66);
    check("t5_bcast_blocked", in_retry, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(); smp();
      check("t5_bcast_blocked_h", in_retry, 1);
      check("t5_m_valid_h", m_valid, 1);
      check("t5_m_data_h", m_data, 8'h22);
    end
    cyc(); m_retry = 0;
    smp();
    check("t5_m_valid_take", m_valid, 1);
    check("t5_bcast_blocked_l", in_retry, 1);
    cyc(); d_retry = 2'b10;
    smp();
    check("t5_bcast_accept", in_retry, 0);
    check("t5_m_valid_off", m_valid, 0);
    cyc(); in_valid = 0; in_bcast = 0;
    smp();
    check("t5_d_valid_b2", d_valid, 2'b11);
    check("t5_d_data_b2", d_data, 96'hB6);
    check("t5_macks", n_macks, 2);

    // 6: reset in BCAST with got=01, then a clean broadcast
    cyc(); ack_valid = 2'b01; ack_data = {8'h00, 8'h04};
    smp();
    check("t6_d_valid_pend", d_valid, 2'b10);
    check("t6_ack_retry", ack_retry, 2'b00);
    cyc(); ack_valid = 2'b00; reset = 1;
    smp();
    check("t6_rst_d_valid", d_valid, 2'b00);
    check("t6_rst_in_retry", in_retry, 1);
    check("t6_rst_ack_retry", ack_retry, 2'b11);
    cyc(); reset = 0;
    smp();
    check("t6_post_d_valid", d_valid, 2'b00);
    check("t6_post_ack_retry", ack_retry, 2'b11);
    check("t6_post_in_retry", in_retry, 0);
    check("t6_post_m_valid", m_valid, 0);
    cyc(); d_retry = 2'b00; in_valid = 1; in_bcast = 1; in_data = 96'hB7;
    smp(); check("t6_in_retry", in_retry, 0);
    cyc(); in_valid = 0; in_bcast = 0; ack_valid = 2'b11; ack_data = {8'h08, 8'h40};
    smp();
    check("t6_d_valid", d_valid, 2'b11);
    check("t6_d_data", d_data, 96'hB7);
    check("t6_ack_retry2", ack_retry, 2'b00);
    cyc(); ack_valid = 2'b00;
    cyc(); smp();
    check("t6_m_valid", m_valid, 1);
    check("t6_m_data", m_data, 8'h48);
    cyc(); smp();
    check("t6_m_valid_off", m_valid, 0);
    check("t6_macks", n_macks, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
